vx_gbus_arbiter: RTL

Sequencer and arbiter placed between the Vortex cache-line memory port and the single-word generic bus memory (`generic_bus_if` master side). It shares that memory between two requesters: Vortex line requests and a host debug port used for program load and memory dump. A Vortex line is serialized into word accesses, reads are reassembled into a line with the tag echoed back, and arbitration between the two requesters is round-robin.

---
 rtl/vx_gbus_arbiter_if.sv | 23 ++
 rtl/vx_gbus_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vx_gbus_arbiter_if.sv
// Single-word generic bus between the line arbiter (master) and the shared memory (slave).
interface vx_gbus_arbiter_if #(
  parameter int WORD_W     = 32,
  parameter int BUS_ADDR_W = 32
);
  logic [BUS_ADDR_W-1:0] bus_addr;
  logic                  bus_ren;
  logic                  bus_wen;
  logic [WORD_W-1:0]     bus_wdata;
  logic [WORD_W/8-1:0]   bus_byten;
  logic [WORD_W-1:0]     bus_rdata;
  logic                  bus_busy;

  modport master (
    output bus_addr, bus_ren, bus_wen, bus_wdata, bus_byten,
    input  bus_rdata, bus_busy
  );

  modport slave (
    input  bus_addr, bus_ren, bus_wen, bus_wdata, bus_byten,
    output bus_rdata, bus_busy
  );
endinterface

// File: rtl/vx_gbus_arbiter.sv
// Round-robin sharing of a single-word generic bus memory between Vortex line
// requests (serialized word by word) and a host debug word port.
module vx_gbus_arbiter #(
  parameter int LINE_W     = 512,
  parameter int WORD_W     = 32,
  parameter int VX_ADDR_W  = 26,
  parameter int TAG_W      = 8,
  parameter int BUS_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req_valid,
  input  logic                  mem_req_rw,
  input  logic [LINE_W/8-1:0]   mem_req_byteen,
  input  logic [VX_ADDR_W-1:0]  mem_req_addr,
  input  logic [LINE_W-1:0]     mem_req_data,
  input  logic [TAG_W-1:0]      mem_req_tag,
  output logic                  mem_req_ready,
  output logic                  mem_rsp_valid,
  output logic [LINE_W-1:0]     mem_rsp_data,
  output logic [TAG_W-1:0]      mem_rsp_tag,
  input  logic                  mem_rsp_ready,
  input  logic                  dbg_req_valid,
  input  logic                  dbg_req_wen,
  input  logic [BUS_ADDR_W-1:0] dbg_req_addr,
  input  logic [WORD_W-1:0]     dbg_req_wdata,
  output logic                  dbg_req_ready,
  output logic                  dbg_rsp_valid,
  output logic [WORD_W-1:0]     dbg_rsp_rdata,
  vx_gbus_arbiter_if.master     gbus,
  output logic                  busy
);
  localparam int WORDS = LINE_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int BYTES = WORD_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, VX_RD, VX_WR, VX_RSP, DBG} state_t;

  state_t                 state;
  logic                   prio_dbg;
  logic [IDX_W-1:0]       idx;
  logic [VX_ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]      line_q;
  logic [LINE_W/8-1:0]    be_q;
  logic                   grant_vx;
  logic                   grant_dbg;
  logic [IDX_W-1:0]       nxt_idx;
  logic [WORD_W-1:0]      nxt_wdata;
  logic [BYTES-1:0]       nxt_be;

  function automatic logic [BUS_ADDR_W-1:0] word_addr(input logic [VX_ADDR_W-1:0] a,
                                                      input logic [IDX_W-1:0] i);
    return BUS_ADDR_W'({a, i, {OFS_W{1'b0}}});
  endfunction

  always_comb begin
    grant_vx      = mem_req_valid && (!dbg_req_valid || !prio_dbg);
    grant_dbg     = dbg_req_valid && !grant_vx;
    mem_req_ready = reset && (state == IDLE) && grant_vx;
    dbg_req_ready = reset && (state == IDLE) && grant_dbg;
    nxt_idx       = idx + 1'b1;
    nxt_wdata     = line_q[int'(nxt_idx)*WORD_W +: WORD_W];
    nxt_be        = be_q[int'(nxt_idx)*BYTES +: BYTES];
  end

  assign mem_rsp_data = line_q;
  assign busy         = (state != IDLE);

  // Bus strobes/address/data are registered and always describe the word held in idx,
  // so they only advance on the edge that completes (or skips) that word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      prio_dbg       <= 1'b0;
      idx            <= '0;
      addr_q         <= '0;
      line_q         <= '0;
      be_q           <= '0;
      mem_rsp_valid  <= 1'b0;
      mem_rsp_tag    <= '0;
      dbg_rsp_valid  <= 1'b0;
      dbg_rsp_rdata  <= '0;
      gbus.bus_addr  <= '0;
      gbus.bus_ren   <= 1'b0;
      gbus.bus_wen   <= 1'b0;
      gbus.bus_wdata <= '0;
      gbus.bus_byten <= '0;
    end else begin
      dbg_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vx) begin
            prio_dbg       <= 1'b1;
            addr_q         <= mem_req_addr;
            mem_rsp_tag    <= mem_req_tag;
            line_q         <= mem_req_data;
            be_q           <= mem_req_byteen;
            idx            <= '0;
            gbus.bus_addr  <= word_addr(mem_req_addr, '0);
            gbus.bus_wdata <= mem_req_data[WORD_W-1:0];
            gbus.bus_byten <= mem_req_rw ? mem_req_byteen[BYTES-1:0] : '1;
            gbus.bus_ren   <= !mem_req_rw;
            gbus.bus_wen   <= mem_req_rw && (|mem_req_byteen[BYTES-1:0]);
            state          <= mem_req_rw ? VX_WR : VX_RD;
          end else if (grant_dbg) begin
            prio_dbg       <= 1'b0;
            gbus.bus_addr  <= dbg_req_addr;
            gbus.bus_wdata <= dbg_req_wdata;
            gbus.bus_byten <= '1;
            gbus.bus_ren   <= !dbg_req_wen;
            gbus.bus_wen   <= dbg_req_wen;
            state          <= DBG;
          end
        end
        VX_RD: begin
          if (!gbus.bus_busy) begin
            line_q[int'(idx)*WORD_W +: WORD_W] <= gbus.bus_rdata;
            if (idx == LAST) begin
              gbus.bus_ren  <= 1'b0;
              mem_rsp_valid <= 1'b1;
              state         <= VX_RSP;
            end else begin
              idx           <= nxt_idx;
              gbus.bus_addr <= word_addr(addr_q, nxt_idx);
            end
          end
        end
        VX_WR: begin
          // A skipped word (strobe low) completes regardless of bus_busy.
          if (!gbus.bus_wen || !gbus.bus_busy) begin
            if (idx == LAST) begin
              gbus.bus_wen <= 1'b0;
              state        <= IDLE;
            end else begin
              idx            <= nxt_idx;
              gbus.bus_addr  <= word_addr(addr_q, nxt_idx);
              gbus.bus_wdata <= nxt_wdata;
              gbus.bus_byten <= nxt_be;
              gbus.bus_wen   <= |nxt_be;
            end
          end
        end
        VX_RSP: begin
          if (mem_rsp_ready) begin
            mem_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        DBG: begin
          if (!gbus.bus_busy) begin
            gbus.bus_ren  <= 1'b0;
            gbus.bus_wen  <= 1'b0;
            dbg_rsp_valid <= 1'b1;
            dbg_rsp_rdata <= gbus.bus_rdata;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
